// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM tile writer: command opcodes, engine states
// and default geometry of the tile RAM.
package vram_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int CMD_OP_WIDTH   = 2;

    typedef enum logic [1:0] {
        OP_SET_ADDR = 2'd0,
        OP_WRITE    = 2'd1,
        OP_FILL     = 2'd2,
        OP_RSVD     = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } engine_state_t;

endpackage

// File: rtl/vram_writer_cmd_fifo.sv
// Synchronous command FIFO between the host port and the write engine.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_en;
    logic             pop_en;

    assign o_full  = (count == FULL_CNT);
    assign o_empty = (count == '0);
    assign push_en = i_push && !o_full;
    assign pop_en  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            if (push_en && !pop_en) begin
                count <= count + ONE_CNT;
            end else if (pop_en && !push_en) begin
                count <= count - ONE_CNT;
            end
        end
    end

endmodule

// File: rtl/vram_writer.sv
// Tile-RAM write engine: queues host commands and replays them into the RAM,
// issuing writes only while the display is in blanking.
module vram_writer
    import vram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    input  logic                  i_blank,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    output logic                  o_busy,
    output logic                  o_cmd_err
);

    localparam int CMD_W = CMD_OP_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic                  ready_en;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CMD_W-1:0]      fifo_head;
    logic                  push;
    logic                  pop;
    cmd_op_t               head_op;
    logic [DATA_WIDTH-1:0] head_data;

    engine_state_t         state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] data_q;

    // Ready stays low through reset and for the first edge afterwards.
    assign o_cmd_ready = ready_en && !fifo_full;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state == ST_IDLE) && !fifo_empty;
    assign head_op     = cmd_op_t'(fifo_head[DATA_WIDTH +: CMD_OP_WIDTH]);
    assign head_data   = fifo_head[DATA_WIDTH-1:0];
    assign o_busy      = !fifo_empty || (state != ST_IDLE);

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  ({i_cmd_op, i_cmd_data}),
        .i_pop   (pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            data_q     <= '0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
            o_cmd_err  <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        case (head_op)
                            OP_SET_ADDR: ptr <= head_data[ADDR_WIDTH-1:0];
                            OP_WRITE: begin
                                data_q <= head_data;
                                state  <= ST_WRITE;
                            end
                            OP_FILL: begin
                                data_q <= head_data;
                                state  <= ST_FILL;
                            end
                            default: o_cmd_err <= 1'b1;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (i_blank) begin
                        o_mem_we   <= 1'b1;
                        o_mem_addr <= ptr;
                        o_mem_din  <= data_q;
                        ptr        <= ptr + ONE_ADDR;
                        state      <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (i_blank) begin
                        o_mem_we   <= 1'b1;
                        o_mem_addr <= ptr;
                        o_mem_din  <= data_q;
                        ptr        <= ptr + ONE_ADDR;
                        // The write to the top address wraps the pointer to 0 and ends the fill.
                        if (ptr == LAST_ADDR) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer: a command-level model feeds a write
// scoreboard, plus directed latency, back-pressure, error and reset sequences.
module tb_vram_writer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        blank;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic        busy;
    logic        cmd_err;

    vram_writer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_data  (cmd_data),
        .i_blank     (blank),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_din   (mem_din),
        .o_busy      (busy),
        .o_cmd_err   (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected RAM writes as {addr, data}, in issue order.
    logic [23:0] sb[$];
    logic [7:0]  m_ptr = 8'h00;
    logic        m_err = 1'b0;
    int          write_count = 0;
    logic        blank_at_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic model_accept(input logic [1:0] op, input logic [15:0] data);
        case (op)
            2'd0: m_ptr = data[7:0];
            2'd1: begin
                sb.push_back({m_ptr, data});
                m_ptr = m_ptr + 8'd1;
            end
            2'd2: begin
                forever begin
                    sb.push_back({m_ptr, data});
                    if (m_ptr == 8'hFF) break;
                    m_ptr = m_ptr + 8'd1;
                end
                m_ptr = 8'h00;
            end
            default: m_err = 1'b1;
        endcase
    endtask

    // Returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [1:0] op, input logic [15:0] data);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("send_ready_timeout", {31'd0, cmd_ready}, 32'd1);
        end else begin
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_data  = data;
            @(posedge clk);
            model_accept(op, data);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input bit toggle, input int max_cycles);
        int cyc = 0;
        int phase = 0;
        while (sb.size() != 0 && cyc < max_cycles) begin
            @(negedge clk);
            #1;
            cyc++;
            if (toggle) begin
                phase++;
                if (phase == 3) begin
                    blank = ~blank;
                    phase = 0;
                end
            end
        end
        check("drain_sb_empty", sb.size(), 0);
        check("busy_after_drain", {31'd0, busy}, 32'd0);
    endtask

    always @(posedge clk) blank_at_edge = blank;

    always @(negedge clk) begin
        if (mem_we) begin
            write_count++;
            check("write_in_blank", {31'd0, blank_at_edge}, 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_write_addr_din", {8'd0, mem_addr, mem_din}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] exp;
                exp = sb.pop_front();
                check("sb_addr", {24'd0, mem_addr}, {24'd0, exp[23:16]});
                check("sb_din", {16'd0, mem_din}, {16'd0, exp[15:0]});
            end
        end
    end

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [7:0]  exp_addr;
        logic [15:0] exp_din;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int wc0;
        int waited;

        vecs[0] = '{addr: 8'h10, data: 16'hABCD, exp_addr: 8'h10, exp_din: 16'hABCD};
        vecs[1] = '{addr: 8'hFF, data: 16'h0001, exp_addr: 8'hFF, exp_din: 16'h0001};
        vecs[2] = '{addr: 8'h00, data: 16'hFFFF, exp_addr: 8'h00, exp_din: 16'hFFFF};
        vecs[3] = '{addr: 8'h7F, data: 16'h5A5A, exp_addr: 8'h7F, exp_din: 16'h5A5A};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 16'h0000;
        blank     = 1'b1;

        // Reset state.
        #12;
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_din", {16'd0, mem_din}, 32'd0);
        check("rst_err", {31'd0, cmd_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_low_before_first_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_release", {31'd0, cmd_ready}, 32'd1);

        // SET_ADDR + WRITE with exact latency and a single-cycle pulse.
        for (int i = 0; i < 4; i++) begin
            send(2'd0, {8'h00, vecs[i].addr});
            send(2'd1, vecs[i].data);
            check("lat_t0_we", {31'd0, mem_we}, 32'd0);
            @(negedge clk);
            check("lat_t1_we", {31'd0, mem_we}, 32'd0);
            @(negedge clk);
            check("lat_t2_we", {31'd0, mem_we}, 32'd1);
            check("lat_t2_addr", {24'd0, mem_addr}, {24'd0, vecs[i].exp_addr});
            check("lat_t2_din", {16'd0, mem_din}, {16'd0, vecs[i].exp_din});
            @(negedge clk);
            check("pulse_one_cycle", {31'd0, mem_we}, 32'd0);
            check("addr_held", {24'd0, mem_addr}, {24'd0, vecs[i].exp_addr});
            check("din_held", {16'd0, mem_din}, {16'd0, vecs[i].exp_din});
            drain(1'b0, 20);
        end

        // Pointer wrap: writes land at 0xFF then 0x00.
        send(2'd0, 16'h00FF);
        send(2'd1, 16'h0001);
        send(2'd1, 16'h0002);
        drain(1'b0, 40);

        // FILL of the top 16 entries with blanking toggling every 3 cycles.
        wc0 = write_count;
        send(2'd0, 16'h00F0);
        send(2'd2, 16'h1234);
        check("busy_during_fill", {31'd0, busy}, 32'd1);
        drain(1'b1, 400);
        check("fill_count", write_count - wc0, 16);
        blank = 1'b1;

        // Short FILL from 0xFC, then a WRITE that must land at 0x00.
        wc0 = write_count;
        send(2'd0, 16'h00FC);
        send(2'd2, 16'hBEEF);
        send(2'd1, 16'h4321);
        drain(1'b0, 60);
        check("fill_fc_count", write_count - wc0, 5);

        // Back-pressure: engine holds the first WRITE while blanking is low.
        blank = 1'b0;
        wc0 = write_count;
        for (int i = 0; i < 5; i++) begin
            send(2'd1, 16'h0100 + 16'(i));
        end
        check("ready_low_when_full", {31'd0, cmd_ready}, 32'd0);
        check("busy_when_full", {31'd0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        check("no_write_blank_low", write_count - wc0, 0);
        blank = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check("ready_rises_after_blank", {31'd0, cmd_ready}, 32'd1);
        check("write_before_ready", (write_count - wc0 >= 1) ? 32'd1 : 32'd0, 32'd1);
        drain(1'b0, 40);
        check("backpressure_count", write_count - wc0, 5);

        // Reserved op: sticky error, no write, later WRITE still executes.
        wc0 = write_count;
        send(2'd3, 16'hDEAD);
        repeat (4) @(negedge clk);
        check("err_set", {31'd0, cmd_err}, {31'd0, m_err});
        check("rsvd_no_write", write_count - wc0, 0);
        send(2'd1, 16'h7777);
        drain(1'b0, 20);
        check("write_after_rsvd", write_count - wc0, 1);
        check("err_sticky", {31'd0, cmd_err}, 32'd1);

        // Asynchronous reset in the middle of a FILL.
        send(2'd0, 16'h0000);
        send(2'd2, 16'h5555);
        send(2'd1, 16'h9999);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        check("we_before_rst", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_ptr = 8'h00;
        m_err = 1'b0;
        check("arst_we", {31'd0, mem_we}, 32'd0);
        check("arst_addr", {24'd0, mem_addr}, 32'd0);
        check("arst_din", {16'd0, mem_din}, 32'd0);
        check("arst_err", {31'd0, cmd_err}, 32'd0);
        check("arst_ready", {31'd0, cmd_ready}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wc0 = write_count;
        @(negedge clk);
        check("ready_after_rerelease", {31'd0, cmd_ready}, 32'd1);
        repeat (50) @(negedge clk);
        check("no_write_after_reset", write_count - wc0, 0);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
